// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL ratio sequencer.
//   pll_seq_state_e : sequencer FSM states
//   pll_cmd_t       : 13-bit SPI command word {ratio, pllen, write, read}
//   mk_cmd          : builds a write command for a given ratio / enable
package pll_seq_pkg;

  localparam int unsigned CMD_W = 13;

  typedef enum logic [2:0] {
    IDLE,
    DIS_SEND,
    DIS_WAIT,
    SETTLE,
    EN_SEND,
    EN_WAIT,
    WAIT_LOCK,
    ERR
  } pll_seq_state_e;

  typedef struct packed {
    logic [9:0] ratio;
    logic       pllen;
    logic       write;
    logic       read;
  } pll_cmd_t;

  // Every command this block issues is a write; only ratio and enable vary.
  function automatic pll_cmd_t mk_cmd(input logic [9:0] ratio_v, input logic pllen_v);
    pll_cmd_t c;
    c.ratio = ratio_v;
    c.pllen = pllen_v;
    c.write = 1'b1;
    c.read  = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/pll_lock_qual.sv
// Lock qualifier: synchronizes the asynchronous PLL lock and qualifies it.
//   clk, rst       : clock, synchronous active-high reset
//   i_lock         : raw asynchronous lock from the PLL
//   i_run          : high while the sequencer waits for lock; counters held at 0 otherwise
//   o_lock_ok_c    : synced lock is high and this cycle completes LOCK_STABLE consecutive highs
//   o_timeout_c    : this cycle is the LOCK_TIMEOUT-th cycle of the wait
//   o_lock_fall_c  : synced lock fell this cycle
// All outputs are decodes of local flops only (no input-to-output paths).
module pll_lock_qual #(
  parameter int unsigned LOCK_STABLE  = 8,
  parameter int unsigned LOCK_TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic i_lock,
  input  logic i_run,
  output logic o_lock_ok_c,
  output logic o_timeout_c,
  output logic o_lock_fall_c
);

  localparam int unsigned ST_W = $clog2(LOCK_STABLE + 1);
  localparam int unsigned TO_W = $clog2(LOCK_TIMEOUT + 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_lock_d;
  logic [ST_W-1:0] r_st_cnt;
  logic [TO_W-1:0] r_to_cnt;

  // Synchronizer, edge history and qualification counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_lock_d <= 1'b0;
      r_st_cnt <= '0;
      r_to_cnt <= '0;
    end else begin
      r_sync1  <= i_lock;
      r_sync2  <= r_sync1;
      r_lock_d <= r_sync2;
      if (!i_run) begin
        r_st_cnt <= '0;
        r_to_cnt <= '0;
      end else begin
        if (!r_sync2) begin
          r_st_cnt <= '0;
        end else if (r_st_cnt != ST_W'(LOCK_STABLE)) begin
          r_st_cnt <= r_st_cnt + ST_W'(1);
        end
        if (r_to_cnt != TO_W'(LOCK_TIMEOUT)) begin
          r_to_cnt <= r_to_cnt + TO_W'(1);
        end
      end
    end
  end

  // Flags fire on the cycle whose closing edge would bring a counter to its
  // threshold, so the sequencer reacts on that same edge.
  assign o_lock_ok_c   = r_sync2 && (r_st_cnt == ST_W'(LOCK_STABLE - 1));
  assign o_timeout_c   = (r_to_cnt == TO_W'(LOCK_TIMEOUT - 1));
  assign o_lock_fall_c = r_lock_d && !r_sync2;

endmodule

// File: rtl/pll_ratio_sequencer.sv
// PLL ratio change sequencer: disable PLL, load new ratio, re-enable, wait for lock.
//   clk, rst        : clock, synchronous active-high reset
//   req_valid/ratio : ratio change request (held by requester until req_ready)
//   req_ready       : high only while idle
//   cmd_word        : {ratio, pllen, write, read} for the SPI master
//   cmd_start       : one-cycle pulse launching an SPI transfer
//   cmd_done        : one-cycle pulse when the SPI transfer finishes
//   pll_lock        : asynchronous lock from the PLL
//   busy            : sequence in progress
//   done/err_range/err_timeout : one-cycle result pulses
//   lock_lost       : sticky loss-of-lock while idle, cleared by clr_lock_lost
//   cur_ratio       : last successfully locked ratio
module pll_ratio_sequencer
  import pll_seq_pkg::*;
#(
  parameter logic [9:0]  RATIO_MIN    = 10'd2,
  parameter logic [9:0]  RATIO_MAX    = 10'd1000,
  parameter int unsigned SETTLE_CYC   = 16,
  parameter int unsigned LOCK_STABLE  = 8,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter logic [9:0]  RST_RATIO    = 10'd6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [9:0]       req_ratio,
  output logic             req_ready,
  output logic [CMD_W-1:0] cmd_word,
  output logic             cmd_start,
  input  logic             cmd_done,
  input  logic             pll_lock,
  output logic             busy,
  output logic             done,
  output logic             err_range,
  output logic             err_timeout,
  output logic             lock_lost,
  input  logic             clr_lock_lost,
  output logic [9:0]       cur_ratio
);

  localparam int unsigned SC_W = $clog2(SETTLE_CYC + 1);

  pll_seq_state_e  r_state;
  logic [9:0]      r_tgt;
  pll_cmd_t        r_cmd;
  logic            r_cmd_start;
  logic            r_busy;
  logic            r_done;
  logic            r_err_range;
  logic            r_err_timeout;
  logic            r_lock_lost;
  logic            r_done_seen;
  logic [9:0]      r_cur_ratio;
  logic [SC_W-1:0] r_settle_cnt;

  logic w_run;
  logic w_lock_ok;
  logic w_timeout;
  logic w_lock_fall;

  assign w_run = (r_state == WAIT_LOCK);

  pll_lock_qual #(
    .LOCK_STABLE  (LOCK_STABLE),
    .LOCK_TIMEOUT (LOCK_TIMEOUT)
  ) u_lock_qual (
    .clk           (clk),
    .rst           (rst),
    .i_lock        (pll_lock),
    .i_run         (w_run),
    .o_lock_ok_c   (w_lock_ok),
    .o_timeout_c   (w_timeout),
    .o_lock_fall_c (w_lock_fall)
  );

  // Sequencer FSM. cmd_word/cmd_start are loaded on entry to a send state
  // (or to ERR), so cmd_start is high for exactly the one cycle spent there.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_tgt         <= '0;
      r_cmd         <= '0;
      r_cmd_start   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err_range   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_done_seen   <= 1'b0;
      r_cur_ratio   <= RST_RATIO;
      r_settle_cnt  <= '0;
    end else begin
      r_cmd_start   <= 1'b0;
      r_done        <= 1'b0;
      r_err_range   <= 1'b0;
      r_err_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_tgt <= req_ratio;
            if ((req_ratio < RATIO_MIN) || (req_ratio > RATIO_MAX)) begin
              r_err_range <= 1'b1;
            end else begin
              r_state     <= DIS_SEND;
              r_busy      <= 1'b1;
              r_cmd       <= mk_cmd(req_ratio, 1'b0);
              r_cmd_start <= 1'b1;
            end
          end
        end
        DIS_SEND: r_state <= DIS_WAIT;
        DIS_WAIT: begin
          if (cmd_done) begin
            r_state      <= SETTLE;
            r_settle_cnt <= '0;
          end
        end
        SETTLE: begin
          if (r_settle_cnt == SC_W'(SETTLE_CYC - 1)) begin
            r_state     <= EN_SEND;
            r_cmd       <= mk_cmd(r_tgt, 1'b1);
            r_cmd_start <= 1'b1;
          end else begin
            r_settle_cnt <= r_settle_cnt + SC_W'(1);
          end
        end
        EN_SEND: r_state <= EN_WAIT;
        EN_WAIT: begin
          if (cmd_done) begin
            r_state <= WAIT_LOCK;
          end
        end
        WAIT_LOCK: begin
          // Lock takes priority over a coincident timeout.
          if (w_lock_ok) begin
            r_cur_ratio <= r_tgt;
            r_done      <= 1'b1;
            r_done_seen <= 1'b1;
            r_state     <= IDLE;
            r_busy      <= 1'b0;
          end else if (w_timeout) begin
            r_err_timeout <= 1'b1;
            r_state       <= ERR;
            r_cmd         <= mk_cmd(r_cur_ratio, 1'b1);
            r_cmd_start   <= 1'b1;
          end
        end
        ERR: begin
          // Restore write in flight; return without qualifying lock.
          if (cmd_done) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky loss-of-lock while idle; set wins over clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_lost <= 1'b0;
    end else if (w_lock_fall && (r_state == IDLE) && r_done_seen) begin
      r_lock_lost <= 1'b1;
    end else if (clr_lock_lost) begin
      r_lock_lost <= 1'b0;
    end
  end

  assign req_ready   = !r_busy;
  assign busy        = r_busy;
  assign cmd_word    = r_cmd;
  assign cmd_start   = r_cmd_start;
  assign done        = r_done;
  assign err_range   = r_err_range;
  assign err_timeout = r_err_timeout;
  assign lock_lost   = r_lock_lost;
  assign cur_ratio   = r_cur_ratio;

endmodule

// File: tb/tb_pll_ratio_sequencer.sv
// Self-checking bench for pll_ratio_sequencer: scoreboard of expected SPI
// command words and result pulses, a range-check vector table, and
// hand-written sequences for settle/lock/timeout/glitch/lock-loss/reset.
module tb_pll_ratio_sequencer;

  localparam int SETTLE_CYC   = 16;
  localparam int LOCK_STABLE  = 8;
  localparam int LOCK_TIMEOUT = 4096;
  localparam int SPI_LAT      = 10;

  localparam int EV_NONE  = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_RANGE = 2;
  localparam int EV_TO    = 3;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [9:0]  req_ratio;
  logic        req_ready;
  logic [12:0] cmd_word;
  logic        cmd_start;
  logic        cmd_done;
  logic        pll_lock;
  logic        busy;
  logic        done;
  logic        err_range;
  logic        err_timeout;
  logic        lock_lost;
  logic        clr_lock_lost;
  logic [9:0]  cur_ratio;

  pll_ratio_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ratio     (req_ratio),
    .req_ready     (req_ready),
    .cmd_word      (cmd_word),
    .cmd_start     (cmd_start),
    .cmd_done      (cmd_done),
    .pll_lock      (pll_lock),
    .busy          (busy),
    .done          (done),
    .err_range     (err_range),
    .err_timeout   (err_timeout),
    .lock_lost     (lock_lost),
    .clr_lock_lost (clr_lock_lost),
    .cur_ratio     (cur_ratio)
  );

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          spi_cnt = 0;
  int          done_cyc = -1;
  int          eto_cyc  = -1;
  int          st_cyc[$];
  int          cd_cyc[$];
  logic [12:0] exp_cmd[$];
  int          exp_evt[$];

  typedef struct {
    logic [9:0] ratio;
    int         exp_starts;
    int         exp_evt;
    logic [9:0] exp_cur;
  } vec_t;

  vec_t tbl[6];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [12:0] cw(input logic [9:0] r, input logic en);
    return {r, en, 1'b1, 1'b0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // SPI master model: cmd_done pulse SPI_LAT cycles after each cmd_start.
  initial begin
    cmd_done = 1'b0;
    forever begin
      @(negedge clk);
      cmd_done = 1'b0;
      if (spi_cnt > 0) begin
        spi_cnt--;
        if (spi_cnt == 0) begin
          cmd_done = 1'b1;
          cd_cyc.push_back(cyc);
        end
      end
      if (cmd_start) spi_cnt = SPI_LAT;
    end
  end

  // Output monitor: pops the scoreboard on every command and result pulse.
  initial begin
    int k;
    forever begin
      @(negedge clk);
      if (cmd_start) begin
        st_cyc.push_back(cyc);
        if (exp_cmd.size() == 0) chk("unexpected_cmd_start", 32'(cmd_word), 32'h1fff_ffff);
        else chk("cmd_word", 32'(cmd_word), 32'(exp_cmd.pop_front()));
      end
      k = done ? EV_DONE : err_range ? EV_RANGE : err_timeout ? EV_TO : EV_NONE;
      if (done && err_timeout) k = 99;
      if (k != EV_NONE) begin
        if (k == EV_DONE) done_cyc = cyc;
        if (k == EV_TO) eto_cyc = cyc;
        chk("result_event", 32'(k), 32'((exp_evt.size() != 0) ? exp_evt.pop_front() : EV_NONE));
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic request(input logic [9:0] r);
    int k = 0;
    while (!req_ready && k < 6000) begin
      @(negedge clk);
      k++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_ratio = r;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("idle_wait", 32'(busy), 32'd0);
  endtask

  task automatic wait_count(input string name, input int which, input int n, input int budget);
    int k = 0;
    int s;
    s = (which == 0) ? st_cyc.size() : cd_cyc.size();
    while (s < n && k < budget) begin
      @(negedge clk);
      k++;
      s = (which == 0) ? st_cyc.size() : cd_cyc.size();
    end
    chk(name, 32'(s >= n), 32'd1);
  endtask

  initial begin
    int lcyc;
    int n0;
    tbl[0] = '{ratio: 10'd1,    exp_starts: 0, exp_evt: EV_RANGE, exp_cur: 10'd300};
    tbl[1] = '{ratio: 10'd1001, exp_starts: 0, exp_evt: EV_RANGE, exp_cur: 10'd300};
    tbl[2] = '{ratio: 10'd0,    exp_starts: 0, exp_evt: EV_RANGE, exp_cur: 10'd300};
    tbl[3] = '{ratio: 10'd1023, exp_starts: 0, exp_evt: EV_RANGE, exp_cur: 10'd300};
    tbl[4] = '{ratio: 10'd1000, exp_starts: 2, exp_evt: EV_DONE,  exp_cur: 10'd1000};
    tbl[5] = '{ratio: 10'd2,    exp_starts: 2, exp_evt: EV_DONE,  exp_cur: 10'd2};

    rst = 1'b1;
    req_valid = 1'b0;
    req_ratio = '0;
    pll_lock = 1'b0;
    clr_lock_lost = 1'b0;
    tick(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_cmd_word", 32'(cmd_word), 32'd0);
    chk("rst_cmd_start", 32'(cmd_start), 32'd0);
    chk("rst_cur_ratio", 32'(cur_ratio), 32'd6);
    chk("rst_lock_lost", 32'(lock_lost), 32'd0);
    chk("rst_flags", 32'({done, err_range, err_timeout}), 32'd0);
    rst = 1'b0;
    tick(2);

    // Normal ratio change to 11: words, settle gap, lock latency.
    st_cyc.delete();
    cd_cyc.delete();
    exp_cmd.push_back(13'h05A);
    exp_cmd.push_back(13'h05E);
    exp_evt.push_back(EV_DONE);
    request(10'd11);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_req_ready", 32'(req_ready), 32'd0);
    wait_count("t1_en_start_wait", 0, 2, 200);
    tick(50);
    pll_lock = 1'b1;
    lcyc = cyc;
    wait_idle(200);
    chk("t1_settle_gap", 32'(st_cyc[1] - cd_cyc[0] - 1), 32'(SETTLE_CYC));
    chk("t1_done_latency", 32'(done_cyc - lcyc), 32'(LOCK_STABLE + 2));
    chk("t1_cur_ratio", 32'(cur_ratio), 32'd11);

    // Lock loss in idle: sticky, then cleared.
    tick(5);
    pll_lock = 1'b0;
    tick(2);
    chk("ll_not_yet", 32'(lock_lost), 32'd0);
    tick(1);
    chk("ll_set", 32'(lock_lost), 32'd1);
    tick(4);
    chk("ll_sticky", 32'(lock_lost), 32'd1);
    clr_lock_lost = 1'b1;
    tick(1);
    clr_lock_lost = 1'b0;
    chk("ll_cleared", 32'(lock_lost), 32'd0);

    // Lock never rises: timeout, restore previous ratio.
    st_cyc.delete();
    cd_cyc.delete();
    exp_cmd.push_back(cw(10'd20, 1'b0));
    exp_cmd.push_back(cw(10'd20, 1'b1));
    exp_cmd.push_back(cw(10'd11, 1'b1));
    exp_evt.push_back(EV_TO);
    request(10'd20);
    wait_idle(LOCK_TIMEOUT + 300);
    chk("to_starts", 32'(st_cyc.size()), 32'd3);
    if (cd_cyc.size() >= 2)
      chk("to_latency", 32'(eto_cyc - (cd_cyc[1] + 1)), 32'(LOCK_TIMEOUT));
    else
      chk("to_cmd_done_count", 32'(cd_cyc.size()), 32'd2);
    chk("to_cur_ratio", 32'(cur_ratio), 32'd11);
    chk("to_lock_lost", 32'(lock_lost), 32'd0);

    // One-cycle lock glitch after 5 stable cycles restarts qualification.
    st_cyc.delete();
    cd_cyc.delete();
    exp_cmd.push_back(cw(10'd300, 1'b0));
    exp_cmd.push_back(cw(10'd300, 1'b1));
    exp_evt.push_back(EV_DONE);
    done_cyc = -1;
    request(10'd300);
    wait_count("gl_en_done_wait", 1, 2, 300);
    tick(3);
    pll_lock = 1'b1;
    tick(5);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    lcyc = cyc;
    wait_idle(200);
    chk("gl_done_latency", 32'(done_cyc - lcyc), 32'(LOCK_STABLE + 2));
    chk("gl_cur_ratio", 32'(cur_ratio), 32'd300);

    // Range boundaries: rejected outside [2,1000], accepted at both ends.
    foreach (tbl[i]) begin
      n0 = st_cyc.size();
      if (tbl[i].exp_starts == 2) begin
        exp_cmd.push_back(cw(tbl[i].ratio, 1'b0));
        exp_cmd.push_back(cw(tbl[i].ratio, 1'b1));
      end
      exp_evt.push_back(tbl[i].exp_evt);
      request(tbl[i].ratio);
      tick(3);
      wait_idle(300);
      tick(2);
      chk($sformatf("tbl%0d_starts", i), 32'(st_cyc.size() - n0), 32'(tbl[i].exp_starts));
      chk($sformatf("tbl%0d_cur_ratio", i), 32'(cur_ratio), 32'(tbl[i].exp_cur));
      chk($sformatf("tbl%0d_evt_pending", i), 32'(exp_evt.size()), 32'd0);
    end

    // Reset during DIS_WAIT; the late cmd_done must be ignored.
    st_cyc.delete();
    cd_cyc.delete();
    exp_cmd.push_back(cw(10'd50, 1'b0));
    request(10'd50);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_req_ready", 32'(req_ready), 32'd1);
    chk("mr_cmd_start", 32'(cmd_start), 32'd0);
    chk("mr_cur_ratio", 32'(cur_ratio), 32'd6);
    chk("mr_cmd_word", 32'(cmd_word), 32'd0);
    tick(15);
    chk("mr_late_done_seen", 32'(cd_cyc.size()), 32'd1);
    chk("mr_still_idle", 32'(busy), 32'd0);
    chk("mr_starts", 32'(st_cyc.size()), 32'd1);
    chk("cmd_queue_empty", 32'(exp_cmd.size()), 32'd0);
    chk("evt_queue_empty", 32'(exp_evt.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_ratio_sequencer.md
Name: pll_ratio_sequencer

Overview:
- Sequences a PLL ratio change through the SPI-attached PLL map: disable PLL, load new ratio, re-enable, wait for qualified lock.
- Builds the 13-bit command word {ratio[9:0], pllen, write, read} for the SPI master and handshakes each transfer.
- Reports busy, done, range error, lock timeout and sticky lock loss to software or a top-level FSM.

Parameters:
- RATIO_MIN, 10'd2, smallest accepted ratio.
- RATIO_MAX, 10'd1000, largest accepted ratio.
- SETTLE_CYC, 16, clk cycles to hold PLL disabled after the disable write completes.
- LOCK_STABLE, 8, consecutive synced-lock-high cycles required to declare lock.
- LOCK_TIMEOUT, 4096, max cycles in WAIT_LOCK before error.
- RST_RATIO, 10'd6, ratio reported after reset.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- req_valid, in, 1, ratio change request.
- req_ratio, in, 10, requested ratio.
- req_ready, out, 1, high only in IDLE.
- cmd_word, out, 13, {ratio, pllen, write, read} for the SPI data_i low bits; upper bits zero at top level.
- cmd_start, out, 1, one-cycle pulse launching an SPI transfer.
- cmd_done, in, 1, one-cycle pulse when the SPI transfer finishes.
- pll_lock, in, 1, asynchronous lock from the PLL.
- busy, out, 1, sequence in progress.
- done, out, 1, one-cycle pulse on successful lock.
- err_range, out, 1, one-cycle pulse on a rejected request.
- err_timeout, out, 1, one-cycle pulse on lock timeout.
- lock_lost, out, 1, sticky flag.
- clr_lock_lost, in, 1, clears lock_lost.
- cur_ratio, out, 10, last successfully locked ratio.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - State IDLE.
  - cmd_word=0, cmd_start=0, busy=0, done=0, err_range=0, err_timeout=0, lock_lost=0.
  - cur_ratio=RST_RATIO; all counters 0; synchronizer flops 0.
- pll_lock passes through a 2-flop synchronizer (lock_s). All lock logic uses lock_s.
- States: IDLE, DIS_SEND, DIS_WAIT, SETTLE, EN_SEND, EN_WAIT, WAIT_LOCK, ERR.
- IDLE:
  - req_ready=1. A request is accepted when req_valid && req_ready; req_ratio is latched into tgt.
  - If tgt < RATIO_MIN or tgt > RATIO_MAX: pulse err_range the next cycle, stay IDLE, issue no SPI traffic.
  - Otherwise go to DIS_SEND.
- DIS_SEND: cmd_word={tgt,0,1,0}; cmd_start=1 for exactly one cycle; go to DIS_WAIT.
- DIS_WAIT: hold cmd_word; on cmd_done go to SETTLE and clear the counter.
- SETTLE: count SETTLE_CYC cycles, then go to EN_SEND.
- EN_SEND: cmd_word={tgt,1,1,0}; one-cycle cmd_start; go to EN_WAIT.
- EN_WAIT: on cmd_done go to WAIT_LOCK with both counters cleared.
- WAIT_LOCK:
  - Stable counter increments while lock_s=1 and resets to 0 when lock_s=0.
  - When it reaches LOCK_STABLE: cur_ratio<=tgt, pulse done, go to IDLE.
  - The timeout counter increments every cycle. If it reaches LOCK_TIMEOUT first: pulse err_timeout, go to ERR. If both thresholds are hit in the same cycle, lock wins.
- ERR:
  - Send {cur_ratio,1,1,0} once (cmd_start pulse, wait cmd_done) to restore the previous ratio.
  - Return to IDLE without waiting for lock.
- busy=1 in every state except IDLE.
- cmd_start is never asserted while a previous transfer is outstanding. A cmd_done arriving outside DIS_WAIT/EN_WAIT/ERR-wait is ignored.
- req_valid while busy is not accepted; the requester holds it until req_ready.
- lock_lost:
  - Set when lock_s falls while in IDLE after at least one done since reset.
  - clr_lock_lost clears it. Set wins if both occur in the same cycle.
- Reset mid-sequence returns to IDLE immediately. cmd_start drops and any pending transfer completion is ignored.
- Counter widths: $clog2(max+1). No wrap is possible before the threshold compares.

Decomposition:
- Package pll_seq_pkg holds:
  - state enum pll_seq_state_e;
  - packed struct pll_cmd_t {logic [9:0] ratio; logic pllen; logic write; logic read;};
  - localparam CMD_W=13.
- One sub-module, pll_lock_qual: 2-flop synchronizer, stable counter and timeout counter, with outputs lock_ok, timeout and lock_fall.

Test Plan:
- Reset, then req_ratio=11 accepted; SPI model returns cmd_done 10 cycles after each cmd_start; lock rises 50 cycles after the enable write. Required:
  - cmd_word 0x05A then 0x05E;
  - SETTLE_CYC gap between the first cmd_done and the second cmd_start;
  - done pulse LOCK_STABLE+2 cycles after lock rises;
  - cur_ratio=11.
- req_ratio=1 and req_ratio=1001 -> err_range pulse each time, zero cmd_start pulses, cur_ratio unchanged.
- Lock never rises after a request for ratio=20 -> err_timeout exactly LOCK_TIMEOUT cycles after entering WAIT_LOCK. Recovery cmd_word={cur_ratio,1,1,0}, then IDLE with cur_ratio still 11.
- Lock glitches low for 1 cycle after 5 stable cycles -> stable count restarts; done only after 8 further consecutive high cycles.
- After a successful lock, drop pll_lock in IDLE -> lock_lost=1 three cycles later; clr_lock_lost -> 0.
- rst pulse during DIS_WAIT -> next cycle IDLE, busy=0, cmd_start=0, cur_ratio=6; a late cmd_done is ignored.
